// File: rtl/dm_responder.sv
// dm_responder: data-memory responder with fixed-latency load/store handshake and store write-log
module dm_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q;
  logic [3:0] be_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] mem [DEPTH];
  logic err_q, wr_q;
  logic [31:0] rdata_q, data_q, log_addr_q;
  logic accept, enter;
  logic cur_we;
  logic [3:0] cur_be;
  logic [31:0] cur_addr, cur_wdata, off, mask, merged;
  logic [DEPTH_LOG2-1:0] idx;
  logic be_ok, in_range, ok;
  assign accept = req_valid && state == IDLE;
  // At LATENCY=1 the commit edge is the accept edge, so checks use the live request then
  assign cur_we    = state == IDLE ? req_we    : we_q;
  assign cur_be    = state == IDLE ? req_be    : be_q;
  assign cur_addr  = state == IDLE ? req_addr  : addr_q;
  assign cur_wdata = state == IDLE ? req_wdata : wdata_q;
  assign off      = cur_addr - BASE;
  assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign be_ok    = (cur_be == 4'b1111 || cur_be == 4'b0011) ? cur_addr[1:0] == 2'd0 :
                    cur_be == 4'b1100 ? cur_addr[1:0] == 2'd2 :
                    cur_be == (4'b0001 << cur_addr[1:0]);
  assign ok       = be_ok && in_range;
  assign mask     = {{8{cur_be[3]}}, {8{cur_be[2]}}, {8{cur_be[1]}}, {8{cur_be[0]}}};
  assign merged   = (mem[idx] & ~mask) | (cur_wdata & mask);
  always_comb begin
    enter   = (state == WAIT && cnt == 4'd0) || (accept && LATENCY == 1);
    state_n = enter ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      data_q     <= '0;
      log_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= accept ? CNT_INIT : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (accept) begin
        we_q    <= req_we;
        be_q    <= req_be;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
      end
      if (enter) begin
        err_q      <= !ok;
        wr_q       <= cur_we && ok;
        rdata_q    <= (!cur_we && ok) ? mem[idx] : '0;
        data_q     <= merged;
        log_addr_q <= BASE + 32'({idx, 2'b00});
        if (cur_we && ok) mem[idx] <= merged;
      end
    end
  end
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
  assign log_valid  = resp_valid && wr_q;
  assign log_pc     = log_valid ? pc_q : '0;
  assign log_addr   = log_valid ? log_addr_q : '0;
  assign log_data   = log_valid ? data_q : '0;
endmodule
